npc_ctrl: RTL and testbench

Next-PC generator and PC write controller for the single-issue MIPS core. Each cycle it computes the next instruction address from the current PC and decoded control (sequential, branch, jump, register jump, exception, eret). It drives the PC register's write-enable and data inputs, and the CP0 EPC write port. It also holds the PC for a fixed number of cycles while a multi-cycle multiply/divide completes, and defers interrupts that arrive during that hold.

---
 rtl/npc_ctrl.sv | 140 ++++++++++++++
 tb/tb_npc_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/npc_ctrl.sv
// Next-PC generator and PC/EPC write controller for the single-issue MIPS core.
// It freezes the PC while a multi-cycle MDU operation runs and defers interrupts that arrive during that freeze.
module npc_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter logic [31:0] EXC_VEC    = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [2:0]  pc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    input  logic [31:0] epc_in,
    input  logic        exc_req,
    input  logic        int_req,
    input  logic        int_en,
    input  logic        mdu_start,
    input  logic        hold_in,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        epc_we,
    output logic [31:0] epc_val,
    output logic        stall,
    output logic        fsm_state
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    logic [0:0]  state;
    logic [5:0]  cnt;
    logic        int_pend;
    logic [31:0] saved_pc4;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] norm_target;
    logic [31:0] target;
    logic [31:0] epc_raw;
    logic        we_raw;
    logic        epc_we_raw;
    logic        int_take_run;
    logic        mdu_issue;
    logic        wait_done;
    logic        service;
    logic        pend_set;

    always_comb begin
        pc4    = pc_in + 32'd4;
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        case (pc_sel)
            3'd1:    norm_target = br_taken ? (pc4 + br_off) : pc4;
            3'd2:    norm_target = {pc4[31:28], target26, 2'b00};
            3'd3:    norm_target = {rs_data[31:2], 2'b00};
            3'd4:    norm_target = epc_in;
            default: norm_target = pc4;
        endcase
    end

    assign int_take_run = int_en & (int_req | int_pend) & ~mdu_start;
    assign mdu_issue    = mdu_start & ~exc_req;
    assign wait_done    = (state == WAIT) && (cnt == 6'd0) && !hold_in;

    // Decision logic; a held cycle never writes the PC or EPC and services nothing.
    always_comb begin
        target     = 32'd0;
        epc_raw    = 32'd0;
        we_raw     = 1'b0;
        epc_we_raw = 1'b0;
        service    = 1'b0;
        stall      = 1'b0;
        if (state == RUN) begin
            we_raw = ~hold_in & ~mdu_issue;
            if (int_take_run) begin
                target     = EXC_VEC;
                epc_raw    = norm_target;
                epc_we_raw = ~hold_in;
                service    = ~hold_in;
            end else if (exc_req) begin
                target     = EXC_VEC;
                epc_raw    = pc_in;
                epc_we_raw = ~hold_in;
            end else begin
                target = norm_target;
            end
        end else begin
            stall  = ~rst;
            target = saved_pc4;
            if (wait_done) begin
                we_raw = 1'b1;
                if (int_pend && int_en) begin
                    target     = EXC_VEC;
                    epc_raw    = saved_pc4;
                    epc_we_raw = 1'b1;
                    service    = 1'b1;
                end
            end
        end
    end

    assign pc_we     = rst ? 1'b0 : we_raw;
    assign epc_we    = rst ? 1'b0 : epc_we_raw;
    assign epc_val   = rst ? 32'd0 : epc_raw;
    assign pc_next   = rst ? 32'd0 : (target | TEXT_BASE);
    assign fsm_state = state;

    assign pend_set = int_req & ((state == WAIT) | mdu_issue | hold_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 6'd0;
            int_pend  <= 1'b0;
            saved_pc4 <= 32'd0;
        end else begin
            if (service) begin
                int_pend <= 1'b0;
            end else if (pend_set) begin
                int_pend <= 1'b1;
            end
            if (state == RUN) begin
                if (mdu_issue && !hold_in) begin
                    state     <= WAIT;
                    cnt       <= 6'(MDU_CYCLES - 1);
                    saved_pc4 <= pc4;
                end
            end else if (!hold_in) begin
                if (cnt == 6'd0) begin
                    state <= RUN;
                end else begin
                    cnt <= cnt - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: the driver queues the expected outputs for every cycle it drives,
// and a monitor on the falling edge pops and compares them.
module tb_npc_ctrl;

    localparam logic [31:0] EXC = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'h0040_0000;
    logic [2:0]  pc_sel = 3'd0;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] target26 = 26'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] epc_in = 32'd0;
    logic        exc_req = 1'b0;
    logic        int_req = 1'b0;
    logic        int_en = 1'b0;
    logic        mdu_start = 1'b0;
    logic        hold_in = 1'b0;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        epc_we;
    logic [31:0] epc_val;
    logic        stall;
    logic        fsm_state;

    int total = 0;
    int bad = 0;
    logic [66:0] exp_q[$];
    string       name_q[$];

    npc_ctrl #(.MDU_CYCLES(32), .EXC_VEC(EXC)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_sel(pc_sel), .br_taken(br_taken),
        .imm16(imm16), .target26(target26), .rs_data(rs_data), .epc_in(epc_in),
        .exc_req(exc_req), .int_req(int_req), .int_en(int_en), .mdu_start(mdu_start),
        .hold_in(hold_in), .pc_we(pc_we), .pc_next(pc_next), .epc_we(epc_we),
        .epc_val(epc_val), .stall(stall), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Packed layout: {pc_we, pc_next, epc_we, epc_val, stall}
    function automatic logic [66:0] mk(input logic we, input logic [31:0] pn,
                                       input logic ewe, input logic [31:0] ev,
                                       input logic st);
        return {we, pn, ewe, ev, st};
    endfunction

    task automatic step(input string name, input logic [66:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [66:0] e;
            logic [66:0] a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pc_we, pc_next, epc_we, epc_val, stall};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got we=%b pc=%h ewe=%b epc=%h st=%b, want we=%b pc=%h ewe=%b epc=%h st=%b",
                         n, a[66], a[65:34], a[33], a[32:1], a[0],
                         e[66], e[65:34], e[33], e[32:1], e[0]);
            end
        end
    end

    // One multi-cycle MDU instruction at 0x00400040; WAIT lasts 32 non-held cycles.
    task automatic run_mdu(input string name, input int hold_at, input int int_at,
                           input int exc_at, input logic want_int_exit);
        int last;
        int held;
        pc_in = 32'h0040_0040; pc_sel = 3'd0; mdu_start = 1'b1;
        step({name, "_issue"}, mk(0, 32'h0040_0044, 0, 0, 0));
        mdu_start = 1'b0;
        last = (hold_at >= 0) ? 34 : 31;
        for (int i = 0; i <= last; i++) begin
            held = (hold_at >= 0 && i >= hold_at && i < hold_at + 3) ? 1 : 0;
            hold_in = (held != 0);
            int_req = (i == int_at);
            exc_req = (i == exc_at || i == exc_at + 1);
            pc_sel  = exc_req ? 3'd2 : 3'd0;
            if (i == last && want_int_exit)
                step({name, "_exit_int"}, mk(1, EXC, 1, 32'h0040_0044, 1));
            else if (i == last)
                step({name, "_exit"}, mk(1, 32'h0040_0044, 0, 0, 1));
            else
                step({name, "_wait"}, mk(0, 32'h0040_0044, 0, 0, 1));
        end
        hold_in = 1'b0; int_req = 1'b0; exc_req = 1'b0; pc_sel = 3'd0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset0", mk(0, 0, 0, 0, 0));
        step("reset1", mk(0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("seq", mk(1, 32'h0040_0004, 0, 0, 0));

        pc_in = 32'h0040_0010; pc_sel = 3'd1; br_taken = 1'b1; imm16 = 16'hFFFC;
        step("br_taken", mk(1, 32'h0040_0004, 0, 0, 0));
        br_taken = 1'b0;
        step("br_not", mk(1, 32'h0040_0014, 0, 0, 0));
        pc_in = 32'h0040_0020; pc_sel = 3'd2; target26 = 26'h010_0008;
        step("jump", mk(1, 32'h0040_0020, 0, 0, 0));
        pc_sel = 3'd3; rs_data = 32'h0040_0103;
        step("jr", mk(1, 32'h0040_0100, 0, 0, 0));
        rs_data = 32'h0000_0010;
        step("jr_bit22", mk(1, 32'h0040_0010, 0, 0, 0));
        pc_sel = 3'd4; epc_in = 32'h0040_0054;
        step("eret", mk(1, 32'h0040_0054, 0, 0, 0));
        pc_sel = 3'd6;
        step("sel6_seq", mk(1, 32'h0040_0024, 0, 0, 0));
        pc_sel = 3'd0; hold_in = 1'b1;
        step("run_hold", mk(0, 32'h0040_0024, 0, 0, 0));
        hold_in = 1'b0;

        pc_in = 32'h0040_0050; exc_req = 1'b1; int_req = 1'b1; int_en = 1'b1;
        step("exc_int", mk(1, EXC, 1, 32'h0040_0054, 0));
        int_req = 1'b0;
        step("exc_only", mk(1, EXC, 1, 32'h0040_0050, 0));
        mdu_start = 1'b1;
        step("exc_mdu", mk(1, EXC, 1, 32'h0040_0050, 0));
        mdu_start = 1'b0; exc_req = 1'b0;
        step("after_exc_mdu", mk(1, 32'h0040_0054, 0, 0, 0));

        int_en = 1'b0;
        run_mdu("mdu_hold", 10, -1, 5, 1'b0);
        pc_in = 32'h0040_0044;
        step("post_mdu", mk(1, 32'h0040_0048, 0, 0, 0));

        int_en = 1'b1;
        run_mdu("mdu_int", -1, 3, -1, 1'b1);
        pc_in = 32'h0040_0004;
        step("pend_cleared", mk(1, 32'h0040_0008, 0, 0, 0));

        int_en = 1'b0;
        run_mdu("mdu_int_off", -1, 2, -1, 1'b0);
        pc_in = 32'h0040_0044;
        step("pend_masked", mk(1, 32'h0040_0048, 0, 0, 0));
        int_en = 1'b1; pc_in = 32'h0040_0048;
        step("pend_taken", mk(1, EXC, 1, 32'h0040_004C, 0));
        pc_in = 32'h0040_0004;
        step("pend_gone", mk(1, 32'h0040_0008, 0, 0, 0));

        pc_in = 32'h0040_0040; mdu_start = 1'b1;
        step("rw_issue", mk(0, 32'h0040_0044, 0, 0, 0));
        mdu_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int_req = (i == 1);
            step("rw_wait", mk(0, 32'h0040_0044, 0, 0, 1));
        end
        int_req = 1'b0; rst = 1'b1;
        step("rw_reset", mk(0, 0, 0, 0, 0));
        rst = 1'b0; pc_in = 32'h0040_0060;
        step("rw_release", mk(1, 32'h0040_0064, 0, 0, 0));
        step("rw_run", mk(1, 32'h0040_0064, 0, 0, 0));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
